// File: rtl/jtag_seq_ctrl.sv
// jtag_seq_ctrl
// -------------
// JTAG master sequencer for a tap_top TAP controller that shares tck_i.
// A single start/busy handshake loads an IR_W-bit instruction and then
// shifts a DR payload of up to DR_MAX bits. TDO is captured during the
// DR shift.
//
// After every reset, five TMS=1 slots and one TMS=0 slot force the TAP
// through Test-Logic-Reset into Run-Test/Idle.
//
// Ports
//   tck_i      : TAP clock; every state change happens on its rising edge
//   rst_ni     : asynchronous active-low reset
//   start_i    : command request (see handshake note below)
//   ir_i       : instruction, bit 0 shifted first
//   dr_len_i   : DR length N (0 = IR only, values above DR_MAX are clamped)
//   dr_data_i  : DR payload, bit i shifted in DR shift slot i
//   tdo_i      : TAP td_o
//   tms_o      : registered TMS to the TAP
//   tdi_o      : registered TDI to the TAP
//   busy_o     : high while initialising or running a command
//   done_o     : one-cycle pulse in the cycle after the last slot
//   dr_q_o     : captured TDO bits; held until the next accept
//
// Handshake: a command is accepted on a rising edge of tck_i where
// start_i=1 and busy_o=0. On that edge ir_i, dr_len_i (clamped) and
// dr_data_i are latched, and dr_q_o is cleared. A start_i seen while
// busy_o=1 is dropped, not queued. busy_o is low in the done_o cycle,
// so start_i held high there starts the next command immediately.

module jtag_seq_ctrl #(
    parameter int IR_W   = 5,
    parameter int DR_MAX = 64,
    parameter int LEN_W  = 7
) (
    input  logic              tck_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [IR_W-1:0]   ir_i,
    input  logic [LEN_W-1:0]  dr_len_i,
    input  logic [DR_MAX-1:0] dr_data_i,
    input  logic              tdo_i,
    output logic              tms_o,
    output logic              tdi_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DR_MAX-1:0] dr_q_o
);

    localparam int IR_IDX_W = (IR_W > 1) ? $clog2(IR_W) : 1;
    localparam int DR_IDX_W = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;

    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(DR_MAX);
    localparam logic [LEN_W-1:0] IR_LAST   = LEN_W'(IR_W - 1);
    // INIT counts 1..5 for the TLR slots and 6 for the RTI slot.
    localparam logic [LEN_W-1:0] INIT_RTI  = LEN_W'(6);
    localparam logic [LEN_W-1:0] HDR_LAST  = LEN_W'(3);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        IDLE     = 3'd1,
        HDR_IR   = 3'd2,
        SHIFT_IR = 3'd3,
        HDR_DR   = 3'd4,
        SHIFT_DR = 3'd5,
        TRAILER  = 3'd6
    } state_e;

    // state_q/cnt_q name the slot currently on tms_o/tdi_o.
    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DR_MAX-1:0]  data_q, data_d;
    logic [DR_MAX-1:0]  cap_q, cap_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   len_clamped;

    assign len_clamped = (dr_len_i > LEN_MAX) ? LEN_MAX : dr_len_i;

    // Next-slot selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        len_d   = len_q;
        data_d  = data_q;
        cap_d   = cap_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            INIT: begin
                if (cnt_q == INIT_RTI) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            IDLE: begin
                if (start_i) begin
                    ir_d    = ir_i;
                    len_d   = len_clamped;
                    data_d  = dr_data_i;
                    cap_d   = '0;
                    busy_d  = 1'b1;
                    state_d = HDR_IR;
                    cnt_d   = '0;
                end
            end
            HDR_IR: begin
                if (cnt_q == HDR_LAST) begin
                    state_d = SHIFT_IR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            SHIFT_IR: begin
                if (cnt_q == IR_LAST) begin
                    // With no DR, Update-IR then RTI is exactly the trailer
                    // pattern, so IR-only commands reuse it.
                    state_d = (len_q == '0) ? TRAILER : HDR_DR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HDR_DR: begin
                if (cnt_q == HDR_LAST) begin
                    state_d = SHIFT_DR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            SHIFT_DR: begin
                // The edge ending DR shift slot i captures TDO bit i.
                cap_d[cnt_q[DR_IDX_W-1:0]] = tdo_i;
                if (cnt_q == len_q - ONE) begin
                    state_d = TRAILER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            TRAILER: begin
                if (cnt_q == ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Pin values for the slot being entered, decoded from the next
    // state and next count so that tms_o/tdi_o stay registered.
    always_comb begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
        unique case (state_d)
            INIT:     tms_d = (cnt_d < INIT_RTI);
            IDLE:     tms_d = 1'b0;
            HDR_IR,
            HDR_DR:   tms_d = (cnt_d < LEN_W'(2));
            SHIFT_IR: begin
                tms_d = (cnt_d == IR_LAST);
                tdi_d = ir_q[cnt_d[IR_IDX_W-1:0]];
            end
            SHIFT_DR: begin
                tms_d = (cnt_d == len_q - ONE);
                tdi_d = data_q[cnt_d[DR_IDX_W-1:0]];
            end
            TRAILER:  tms_d = (cnt_d == '0);
            default:  tms_d = 1'b1;
        endcase
    end

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ir_q    <= '0;
            len_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tms_o  = tms_q;
    assign tdi_o  = tdi_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign dr_q_o = cap_q;

endmodule

// File: tb/tb_jtag_seq_ctrl.sv
module tb_jtag_seq_ctrl;

  localparam int IR_W   = 5;
  localparam int DR_MAX = 64;
  localparam int LEN_W  = 7;

  // clock / reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [IR_W-1:0]   ir = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [DR_MAX-1:0] data = '0;
  logic              tdo = 1'b0;
  logic              tms;
  logic              tdi;
  logic              busy;
  logic              done;
  logic [DR_MAX-1:0] drq;

  int errors = 0;
  int checks = 0;

  jtag_seq_ctrl #(.IR_W(IR_W), .DR_MAX(DR_MAX), .LEN_W(LEN_W)) dut (
    .tck_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .ir_i      (ir),
    .dr_len_i  (len),
    .dr_data_i (data),
    .tdo_i     (tdo),
    .tms_o     (tms),
    .tdi_o     (tdi),
    .busy_o    (busy),
    .done_o    (done),
    .dr_q_o    (drq)
  );

  // scoreboard: expected {tms,tdi} per slot of the running command
  logic [1:0] exp_q[$];

  // Reference slot stream built straight from the TAP walk of a command.
  function automatic void build_stream(input logic [IR_W-1:0] c_ir, input int n,
                                       input logic [DR_MAX-1:0] c_data);
    exp_q.delete();
    exp_q.push_back(2'b10);  // Select-DR
    exp_q.push_back(2'b10);  // Select-IR
    exp_q.push_back(2'b00);  // Capture-IR
    exp_q.push_back(2'b00);  // Shift-IR
    for (int i = 0; i < IR_W; i++)
      exp_q.push_back({(i == IR_W - 1) ? 1'b1 : 1'b0, c_ir[i]});
    exp_q.push_back(2'b10);  // Update-IR
    if (n > 0) begin
      exp_q.push_back(2'b10);  // Select-DR
      exp_q.push_back(2'b00);  // Capture-DR
      exp_q.push_back(2'b00);  // Shift-DR
      for (int i = 0; i < n; i++)
        exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, c_data[i]});
      exp_q.push_back(2'b10);  // Update-DR
    end
    exp_q.push_back(2'b00);  // Run-Test/Idle
  endfunction

  // driver: INIT walk after reset release (caller releases at a negedge)
  task automatic check_init();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (tms !== ((k <= 5) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL init_tms edge %0d: got %b want %b", k, tms, (k <= 5));
      end
      checks++;
      if (tdi !== 1'b0) begin
        errors++;
        $display("FAIL init_tdi edge %0d: got %b want 0", k, tdi);
      end
      checks++;
      if (busy !== ((k < 7) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL init_busy edge %0d: got %b want %b", k, busy, (k < 7));
      end
    end
  endtask

  // driver: present a command at a negedge; accepted at the next posedge
  task automatic issue(input logic [IR_W-1:0] c_ir, input logic [LEN_W-1:0] c_len,
                       input logic [DR_MAX-1:0] c_data);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL issue_idle: busy got %b want 0", busy);
    end
    ir = c_ir;
    len = c_len;
    data = c_data;
    start = 1'b1;
  endtask

  // Follows one accepted command slot by slot, drives tdo in DR shift
  // slots, then checks the done cycle and captured data.
  task automatic check_cmd(input logic [IR_W-1:0] c_ir, input logic [LEN_W-1:0] c_len,
                           input logic [DR_MAX-1:0] c_data, input logic [DR_MAX-1:0] c_tdo,
                           input bit pulse_mid, input bit keep_start,
                           input logic [IR_W-1:0] n_ir, input logic [LEN_W-1:0] n_len,
                           input logic [DR_MAX-1:0] n_data);
    int n;
    int total;
    int pslot;
    logic [1:0] s;
    logic [DR_MAX-1:0] exp_dr;
    n = (c_len > LEN_W'(DR_MAX)) ? DR_MAX : int'(c_len);
    build_stream(c_ir, n, c_data);
    total = exp_q.size();
    exp_dr = '0;
    for (int i = 0; i < n; i++) exp_dr[i] = c_tdo[i];
    pslot = $urandom_range(total - 1, 2);
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (keep_start) begin
          ir = n_ir;
          len = n_len;
          data = n_data;
        end else begin
          start = 1'b0;
          ir = IR_W'($urandom);
          len = LEN_W'($urandom);
          data = {$urandom, $urandom};
        end
      end
      if (pulse_mid && k == pslot) start = 1'b1;
      if (pulse_mid && k == pslot + 1) start = 1'b0;
      if (k >= 14 && k < 14 + n) tdo = c_tdo[k - 14];
      else tdo = 1'($urandom);
      s = exp_q.pop_front();
      checks++;
      if (tms !== s[1]) begin
        errors++;
        $display("FAIL slot_tms S%0d: got %b want %b", k, tms, s[1]);
      end
      checks++;
      if (tdi !== s[0]) begin
        errors++;
        $display("FAIL slot_tdi S%0d: got %b want %b", k, tdi, s[0]);
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL slot_status S%0d: busy/done got %b%b want 10", k, busy, done);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle N=%0d: busy/done got %b%b want 01", n, busy, done);
    end
    checks++;
    if (drq !== exp_dr) begin
      errors++;
      $display("FAIL dr_q N=%0d: got %h want %h", n, drq, exp_dr);
    end
    checks++;
    if (tms !== 1'b0 || tdi !== 1'b0) begin
      errors++;
      $display("FAIL idle_pins: tms/tdi got %b%b want 00", tms, tdi);
    end
    if (!keep_start) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL after_done: busy/done got %b%b want 00", busy, done);
      end
      checks++;
      if (drq !== exp_dr) begin
        errors++;
        $display("FAIL dr_q_hold: got %h want %h", drq, exp_dr);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tms !== 1'b1 || tdi !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || drq !== '0) begin
      errors++;
      $display("FAIL reset_values: tms/tdi/busy/done got %b%b%b%b dr_q %h want 1010 0",
               tms, tdi, busy, done, drq);
    end
    rst_n = 1'b1;
    check_init();
  endtask

  task automatic test_full_length();
    issue(5'b11011, 7'd64, {DR_MAX{1'b1}});
    check_cmd(5'b11011, 7'd64, {DR_MAX{1'b1}}, {DR_MAX{1'b1}}, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_short_capture();
    logic [DR_MAX-1:0] pat;
    pat = 64'hC3;
    issue(IR_W'($urandom), 7'd8, 64'hA5);
    check_cmd(ir, 7'd8, 64'hA5, pat, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_ir_only();
    logic [IR_W-1:0] r_ir;
    logic [DR_MAX-1:0] r_data;
    r_ir = IR_W'($urandom);
    r_data = {$urandom, $urandom};
    issue(r_ir, 7'd0, r_data);
    check_cmd(r_ir, 7'd0, r_data, {$urandom, $urandom}, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_clamp_and_ignore();
    logic [IR_W-1:0] r_ir;
    logic [DR_MAX-1:0] r_data;
    r_ir = IR_W'($urandom);
    r_data = {$urandom, $urandom};
    issue(r_ir, 7'd100, r_data);
    check_cmd(r_ir, 7'd100, r_data, {$urandom, $urandom}, 1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_back_to_back();
    logic [IR_W-1:0] a_ir, b_ir;
    logic [LEN_W-1:0] a_len, b_len;
    logic [DR_MAX-1:0] a_data, b_data;
    a_ir = IR_W'($urandom);
    b_ir = IR_W'($urandom);
    a_len = LEN_W'($urandom_range(12, 1));
    b_len = LEN_W'($urandom_range(20, 0));
    a_data = {$urandom, $urandom};
    b_data = {$urandom, $urandom};
    issue(a_ir, a_len, a_data);
    check_cmd(a_ir, a_len, a_data, {$urandom, $urandom}, 1'b0, 1'b1, b_ir, b_len, b_data);
    check_cmd(b_ir, b_len, b_data, {$urandom, $urandom}, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_random();
    logic [IR_W-1:0] r_ir;
    logic [LEN_W-1:0] r_len;
    logic [DR_MAX-1:0] r_data;
    for (int t = 0; t < 8; t++) begin
      r_ir = IR_W'($urandom);
      r_len = LEN_W'($urandom_range(70, 0));
      r_data = {$urandom, $urandom};
      issue(r_ir, r_len, r_data);
      check_cmd(r_ir, r_len, r_data, {$urandom, $urandom}, t[0], 1'b0, '0, '0, '0);
    end
  endtask

  task automatic test_reset_mid();
    issue(IR_W'($urandom), 7'd20, {$urandom, $urandom});
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      tdo = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tms !== 1'b1 || tdi !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || drq !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: tms/tdi/busy/done got %b%b%b%b dr_q %h want 1010 0",
               tms, tdi, busy, done, drq);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_hold: busy/done got %b%b want 10", busy, done);
    end
    rst_n = 1'b1;
    check_init();
    issue(5'b00110, 7'd5, 64'h15);
    check_cmd(5'b00110, 7'd5, 64'h15, 64'h0A, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_full_length();
    test_short_capture();
    test_ir_only();
    test_clamp_and_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
